// File: rtl/quant_packer.sv
// quant_packer: ReLU + int8 saturation, 4-lane word packing and a small output FIFO
module quant_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SATC_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic signed [31:0] data_in,
  input  logic               relu_en,
  input  logic               flush,
  input  logic               clear_status,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [3:0]         out_byte_en,
  input  logic               out_ready,
  output logic               in_ready,
  output logic               overflow,
  output logic [SATC_W-1:0]  sat_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic signed [31:0] w_r;
  logic               w_clamp;
  logic [7:0]         w_q;
  logic [1:0]         r_lane;
  logic [23:0]        r_hold;
  logic [2:0]         w_n;
  logic [23:0]        w_hold_nx;
  logic               w_full_word;
  logic               w_push;
  logic [35:0]        w_push_word;
  logic [35:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic               w_pop;
  logic               w_accept;
  logic               w_drop;
  logic               r_overflow;
  logic [SATC_W-1:0]  r_sat;

  // ReLU then clamp to int8; ReLU zeroing never counts as a clamp
  always_comb begin
    w_r     = (relu_en && data_in < 0) ? '0 : data_in;
    w_clamp = (w_r > 127) || (w_r < -128);
    w_q     = (w_r > 127) ? 8'h7F : (w_r < -128) ? 8'h80 : w_r[7:0];
  end

  // Lane merge, full-word/partial-flush push decision and FIFO handshake
  always_comb begin
    w_full_word = valid_in && r_lane == 2'd3;
    w_n         = {1'b0, r_lane} + {2'b0, valid_in};
    w_hold_nx   = (valid_in && !w_full_word) ? (r_hold | (24'(w_q) << {r_lane, 3'b000})) : r_hold;
    w_push      = w_full_word || (flush && w_n != 3'd0);
    w_push_word = w_full_word ? {4'hF, w_q, r_hold} : {(4'd1 << w_n) - 4'd1, 8'h00, w_hold_nx};
    w_pop       = r_count != '0 && out_ready;
    w_accept    = w_push && (r_count != DEPTH_C || w_pop);
    w_drop      = w_push && !w_accept;
  end

  assign out_valid   = r_count != '0;
  assign out_data    = out_valid ? r_mem[r_rptr][31:0] : '0;
  assign out_byte_en = out_valid ? r_mem[r_rptr][35:32] : '0;
  assign in_ready    = r_count < DEPTH_C;
  assign overflow    = r_overflow;
  assign sat_count   = r_sat;

  // Packing state restarts at lane 0 after every push, even a dropped one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
      r_hold <= '0;
    end else if (w_push) begin
      r_lane <= '0;
      r_hold <= '0;
    end else begin
      r_lane <= w_n[1:0];
      r_hold <= w_hold_nx;
    end
  end

  // FIFO storage; stale entries are masked by out_valid so no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wptr] <= w_push_word;
  end

  // FIFO pointers and occupancy; a push into a full FIFO only fits alongside a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= (w_accept && !w_pop) ? r_count + (AW+1)'(1) :
                 (!w_accept && w_pop) ? r_count - (AW+1)'(1) : r_count;
    end
  end

  // Sticky overflow and saturating clamp counter; clear beats a same-cycle event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_sat      <= '0;
    end else if (clear_status) begin
      r_overflow <= 1'b0;
      r_sat      <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (valid_in && w_clamp && !(&r_sat)) r_sat <= r_sat + SATC_W'(1);
    end
  end
endmodule

// File: tb/tb_quant_packer.sv
// tb_quant_packer: scoreboard-driven bench for the int8 packer and its output FIFO
module tb_quant_packer;
  localparam int D  = 4;
  localparam int SW = 16;

  logic               clk = 0, rst_n = 0, valid_in = 0, relu_en = 0, flush = 0;
  logic               clear_status = 0, out_ready = 0;
  logic signed [31:0] data_in = 0;
  logic               out_valid, in_ready, overflow;
  logic [31:0]        out_data;
  logic [3:0]         out_byte_en;
  logic [SW-1:0]      sat_count;
  int                 vectors = 0, miscompares = 0;
  logic [35:0]        sq[$];
  logic [35:0]        exp_w;

  always #5 clk = ~clk;

  quant_packer #(.FIFO_DEPTH(D), .SATC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .relu_en(relu_en),
    .flush(flush), .clear_status(clear_status), .out_valid(out_valid), .out_data(out_data),
    .out_byte_en(out_byte_en), .out_ready(out_ready), .in_ready(in_ready),
    .overflow(overflow), .sat_count(sat_count)
  );

  function automatic logic [7:0] q8(input logic signed [31:0] d, input logic relu);
    logic signed [31:0] r;
    r = (relu && d < 0) ? 32'sd0 : d;
    if (r > 127) return 8'h7F;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (sq.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got be=%h data=%h, required no word", out_byte_en, out_data);
      end else begin
        exp_w = sq.pop_front();
        if ({out_byte_en, out_data} !== exp_w) begin
          miscompares++;
          $display("FAIL pop_word: got be=%h data=%h, required be=%h data=%h",
                   out_byte_en, out_data, exp_w[35:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic send(input logic v, input logic signed [31:0] d, input logic r, input logic f);
    valid_in = v; data_in = d; relu_en = r; flush = f;
    @(posedge clk); #1;
    valid_in = 0; flush = 0;
  endtask

  task automatic pulse_clear();
    clear_status = 1;
    @(posedge clk); #1;
    clear_status = 0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && (sq.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    vectors++; if (out_byte_en !== 4'h0) begin miscompares++; $display("FAIL rst_byte_en: got %h, required 0", out_byte_en); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
    vectors++; if (sat_count !== '0) begin miscompares++; $display("FAIL rst_sat_count: got %0d, required 0", sat_count); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1;
    sq.push_back({4'hF, 32'h807FFF01});
    send(1, 1, 0, 0); send(1, -1, 0, 0); send(1, 200, 0, 0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: got %b, required 0", out_valid); end
    send(1, -300, 0, 0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: got %b, required 1", out_valid); end
    vectors++; if (sat_count !== 16'd2) begin miscompares++; $display("FAIL basic_sat: got %0d, required 2", sat_count); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_single_pop: got %b, required 0", out_valid); end
    pulse_clear();
    vectors++; if (sat_count !== 16'd0) begin miscompares++; $display("FAIL clear_sat: got %0d, required 0", sat_count); end
    sq.push_back({4'hF, 32'h007F7F00});
    send(1, -5, 1, 0); send(1, 127, 1, 0); send(1, 128, 1, 0); send(1, -200, 1, 0);
    vectors++; if (sat_count !== 16'd1) begin miscompares++; $display("FAIL relu_sat: got %0d, required 1", sat_count); end
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL relu_drain: got %0d pending, required 0", sq.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1;
    sq.push_back({4'h3, 32'h00002010});
    send(1, 32'h10, 0, 0); send(1, 32'h20, 0, 0); send(0, 0, 0, 1);
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL flush_partial: got %0d pending, required 0", sq.size()); end
    send(0, 0, 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_empty: got %b, required 0", out_valid); end
    sq.push_back({4'h7, 32'h00302010});
    send(1, 32'h10, 0, 0); send(1, 32'h20, 0, 0); send(1, 32'h30, 0, 1);
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL flush_with_sample: got %0d pending, required 0", sq.size()); end
    sq.push_back({4'hF, 32'h04030201});
    send(1, 1, 0, 0); send(1, 2, 0, 0); send(1, 3, 0, 0); send(1, 4, 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if (sq.size() != 0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_full_word: got %0d pending valid=%b, required 0 pending valid=0", sq.size(), out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic signed [31:0] d;
    pulse_clear();
    out_ready = 0;
    w = '0;
    for (int i = 0; i < 4*D+4; i++) begin
      d = i*37 - 350;
      w[(i%4)*8 +: 8] = q8(d, 0);
      if (i%4 == 3 && i/4 < D) sq.push_back({4'hF, w});
      send(1, d, 0, 0);
      if (i == 4*D-1) begin
        vectors++; if (overflow !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_full: got ovf=%b in_ready=%b, required ovf=0 in_ready=0", overflow, in_ready); end
      end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (out_valid !== 1'b1 || {out_byte_en, out_data} !== sq[0]) begin miscompares++; $display("FAIL ovf_head_stable: got valid=%b %h_%h, required valid=1 %h", out_valid, out_byte_en, out_data, sq[0]); end
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL ovf_drain: got %0d pending, required 0", sq.size()); end
    pulse_clear();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [31:0] w;
    logic signed [31:0] d;
    out_ready = 0;
    w = '0;
    for (int i = 0; i < 4*D+4; i++) begin
      d = 100 - i*13;
      w[(i%4)*8 +: 8] = q8(d, 0);
      if (i%4 == 3) sq.push_back({4'hF, w});
      if (i == 4*D+3) out_ready = 1;
      send(1, d, 0, 0);
      out_ready = 0;
    end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_ovf: got %b, required 0", overflow); end
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL fullpop_count: got in_ready=%b valid=%b, required 0 and 1", in_ready, out_valid); end
    out_ready = 1;
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL fullpop_drain: got %0d pending, required 0", sq.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    send(1, 50, 0, 0); send(1, -600, 0, 0);
    rst_n = 0;
    #2;
    vectors++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_byte_en !== 4'h0) begin miscompares++; $display("FAIL midrst_out: got valid=%b data=%h be=%h, required 0", out_valid, out_data, out_byte_en); end
    vectors++; if (in_ready !== 1'b1 || overflow !== 1'b0 || sat_count !== '0) begin miscompares++; $display("FAIL midrst_status: got in_ready=%b ovf=%b sat=%0d, required 1 0 0", in_ready, overflow, sat_count); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    sq.push_back({4'hF, 32'h08070605});
    send(1, 5, 0, 0); send(1, 6, 0, 0); send(1, 7, 0, 0); send(1, 8, 0, 0);
    wait_empty();
    vectors++; if (sq.size() != 0) begin miscompares++; $display("FAIL midrst_word: got %0d pending, required 0", sq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end
endmodule
